sevenseg_scan_n: RTL and testbench

Parametrised multiplexed seven-segment driver for DIGITS common-anode digits with active-low segments, anodes and decimal point. It replaces the fixed 4-digit hex scanner and adds:
- a latched load handshake;
- a sequential binary-to-BCD (double-dabble) decimal mode;
- per-digit decimal points;
- leading-zero blanking.

It sits between any register-mapped value source and the board display pins.

---
 rtl/sevenseg_scan_n.sv | 174 +++++++++++++++++
 tb/tb_sevenseg_scan_n.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_n.sv
// Multiplexed seven-segment driver for DIGITS common-anode digits: hex or double-dabble decimal, dp, blanking.
// Optional define BRIGHTNESS_PWM_EN adds a 4-bit brightness input that gates the anode within each slot.
module sevenseg_scan_n #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 16384
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  mode,
    input  logic                  blank_lz,
    input  logic                  load,
`ifdef BRIGHTNESS_PWM_EN
    input  logic [3:0]            brightness,
`endif
    output logic                  busy,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  dp
);
    localparam int NB  = 4 * DIGITS;
    localparam int AW  = NB + 4;
    // Counter is at least 4 bits so the brightness compare always has a 4-bit window.
    localparam int CW  = ($clog2(REFRESH_DIV) < 4) ? 4 : $clog2(REFRESH_DIV);
    localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int ITW = $clog2(NB + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [IW-1:0]   idx_q;
    logic [AW-1:0]   bcd_q, corr, shifted;
    logic [NB-1:0]   sh_q;
    logic [ITW-1:0]  it_q;
    logic            carry, ovf_acc_q;
    logic [DIGITS-1:0] lat_dp_q;
    logic            lat_blank_q;
    logic [NB-1:0]   disp_nib_q;
    logic [DIGITS-1:0] disp_dp_q;
    logic            disp_blank_q, disp_ovf_q;
    logic [6:0]      seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d, zero_up;
    logic            dp_q, dp_d, all_zero, zab, dpb, pwm_on;
    logic [3:0]      nib;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (cnt_q == CW'(REFRESH_DIV - 1)) begin
            cnt_q <= '0;
            idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (load && mode) state_d = S_SHIFT;
            S_SHIFT: if (it_q == ITW'(NB - 1)) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
    end

    // One double-dabble step: add-3 on every nibble >= 5, then shift in the next binary MSB.
    always_comb begin
        corr = bcd_q;
        for (int i = 0; i <= DIGITS; i++)
            if (corr[4*i +: 4] >= 4'd5) corr[4*i +: 4] = corr[4*i +: 4] + 4'd3;
        carry   = corr[AW-1];
        shifted = {corr[AW-2:0], sh_q[NB-1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bcd_q <= '0; sh_q <= '0; it_q <= '0; ovf_acc_q <= 1'b0;
            lat_dp_q <= '0; lat_blank_q <= 1'b0;
            disp_nib_q <= '0; disp_dp_q <= '0; disp_blank_q <= 1'b0; disp_ovf_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (load) begin
                    if (mode) begin
                        bcd_q <= '0; sh_q <= value; it_q <= '0; ovf_acc_q <= 1'b0;
                        lat_dp_q <= dp_in; lat_blank_q <= blank_lz;
                    end else begin
                        disp_nib_q <= value; disp_dp_q <= dp_in;
                        disp_blank_q <= blank_lz; disp_ovf_q <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    bcd_q     <= shifted;
                    sh_q      <= sh_q << 1;
                    it_q      <= it_q + 1'b1;
                    ovf_acc_q <= ovf_acc_q | carry;
                end
                default: begin
                    disp_nib_q   <= bcd_q[NB-1:0];
                    disp_ovf_q   <= ovf_acc_q | (|bcd_q[AW-1:NB]);
                    disp_dp_q    <= lat_dp_q;
                    disp_blank_q <= lat_blank_q;
                end
            endcase
        end
    end

`ifdef BRIGHTNESS_PWM_EN
    always_comb pwm_on = (cnt_q[CW-1 -: 4] <= brightness);
`else
    always_comb pwm_on = 1'b1;
`endif

    always_comb begin
        zero_up  = '0;
        all_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero   = all_zero & (disp_nib_q[4*i +: 4] == 4'd0);
            zero_up[i] = all_zero;
        end
        nib = '0; zab = 1'b0; dpb = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (idx_q == IW'(i)) begin
                nib = disp_nib_q[4*i +: 4];
                zab = zero_up[i];
                dpb = disp_dp_q[i];
            end
        if (disp_ovf_q)                                  seg_d = 7'b0111111;
        else if (disp_blank_q && zab && idx_q != '0)     seg_d = 7'h7F;
        else                                             seg_d = hex7(nib);
        an_d = ~(DIGITS'(1) << idx_q);
        dp_d = ~dpb;
        if (!pwm_on) begin
            an_d  = '1;
            seg_d = 7'h7F;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q <= 7'h7F; an_q <= '1; dp_q <= 1'b1;
        end else begin
            seg_q <= seg_d; an_q <= an_d; dp_q <= dp_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = dp_q;
endmodule

// File: tb/tb_sevenseg_scan_n.sv
// Randomized self-checking bench for sevenseg_scan_n (DIGITS=4, REFRESH_DIV=4) against a transaction-level display model.
module tb_sevenseg_scan_n;
    logic clk = 1'b0, reset = 1'b1, mode = 1'b0, blank_lz = 1'b0, load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic        busy, dp;
    logic [6:0]  seg;
    logic [3:0]  an;

    int n_tests = 0, n_fail = 0;

    sevenseg_scan_n #(.DIGITS(4), .REFRESH_DIV(4)) dut (
        .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .mode(mode),
        .blank_lz(blank_lz), .load(load), .busy(busy), .seg(seg), .an(an), .dp(dp));

    always #5 clk = ~clk;

    logic [6:0] HEX7 [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    int POW10 [4] = '{1, 10, 100, 1000};

    // Model: display contents as digits, scan position from cycles since reset, pending decimal result.
    int k, pend_at, d, v;
    int m_nib [4];
    int p_nib [4];
    logic pend_v, busy_before, z;
    logic [3:0] m_dp, p_dp;
    logic m_blank, m_ovf, p_blank, p_ovf;
    logic [6:0] exp_seg;
    logic [3:0] exp_an;
    logic exp_dp, exp_busy;

    always @(posedge clk) begin
        if (reset) begin
            k = 0; pend_v = 1'b0;
            for (int i = 0; i < 4; i++) m_nib[i] = 0;
            m_dp = '0; m_blank = 1'b0; m_ovf = 1'b0;
            exp_seg = 7'h7F; exp_an = 4'hF; exp_dp = 1'b1; exp_busy = 1'b0;
        end else begin
            d = (k / 4) % 4;
            z = 1'b1;
            for (int i = 3; i >= d; i--) if (m_nib[i] != 0) z = 1'b0;
            if (m_ovf)                        exp_seg = 7'b0111111;
            else if (m_blank && d != 0 && z)  exp_seg = 7'h7F;
            else                              exp_seg = HEX7[m_nib[d]];
            exp_an = ~(4'b0001 << d);
            exp_dp = ~m_dp[d];
            busy_before = pend_v && (k <= pend_at);
            if (pend_v && k == pend_at) begin
                for (int i = 0; i < 4; i++) m_nib[i] = p_nib[i];
                m_dp = p_dp; m_blank = p_blank; m_ovf = p_ovf; pend_v = 1'b0;
            end
            if (load && !busy_before) begin
                if (!mode) begin
                    for (int i = 0; i < 4; i++) m_nib[i] = int'(value[4*i +: 4]);
                    m_dp = dp_in; m_blank = blank_lz; m_ovf = 1'b0;
                end else begin
                    v = int'(value);
                    for (int i = 0; i < 4; i++) p_nib[i] = (v / POW10[i]) % 10;
                    p_ovf = (v >= 10000); p_dp = dp_in; p_blank = blank_lz;
                    pend_v = 1'b1; pend_at = k + 17;
                end
            end
            exp_busy = pend_v && (k < pend_at);
            k++;
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({seg, an, dp, busy} !== {7'h7F, 4'hF, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_vals: got seg=%b an=%b dp=%b busy=%b want 1111111/1111/1/0", seg, an, dp, busy);
        end
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (an !== 4'b1110 || seg !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_release: got an=%b seg=%b want 1110/1000000", an, seg);
        end
    endtask

    task automatic test_hex_scan();
        logic [3:0] prev_an;
        logic [3:0] an_seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [6:0] seg_seq [4] = '{7'b0001110, 7'b1111001, 7'b0000000, 7'b0001000};
        int bound;
        value = 16'hA81F; dp_in = 4'b0000; mode = 1'b0; blank_lz = 1'b0; load = 1'b1;
        @(negedge clk); load = 1'b0;
        repeat (3) @(negedge clk);
        prev_an = an; bound = 0;
        @(negedge clk);
        while (!(prev_an == 4'b0111 && an == 4'b1110) && bound < 40) begin
            prev_an = an; bound++; @(negedge clk);
        end
        n_tests++;
        if (bound >= 40) begin n_fail++; $display("FAIL hex_wrap_wait: no 0111->1110 step within 40 cycles, got an=%b", an); end
        for (int s = 0; s < 5; s++) begin
            n_tests++;
            if (an !== an_seq[s % 4] || seg !== seg_seq[s % 4]) begin
                n_fail++;
                $display("FAIL hex_slot%0d: got an=%b seg=%b want %b/%b", s, an, seg, an_seq[s % 4], seg_seq[s % 4]);
            end
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_decimal();
        int cnt;
        value = 16'd1234; dp_in = 4'b0000; mode = 1'b1; blank_lz = 1'b0; load = 1'b1;
        @(negedge clk); load = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            if (cnt == 5) begin value = 16'hFFFF; mode = 1'b0; load = 1'b1; end
            else load = 1'b0;
            @(negedge clk);
        end
        load = 1'b0;
        n_tests++;
        if (cnt !== 17) begin n_fail++; $display("FAIL dec_busy_len: got %0d cycles want 17", cnt); end
        @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            logic [6:0] want;
            case (an)
                4'b1110: want = 7'b0011001;
                4'b1101: want = 7'b0110000;
                4'b1011: want = 7'b0100100;
                default: want = 7'b1111001;
            endcase
            n_tests++;
            if (seg !== want || {an, dp, busy} !== {exp_an, exp_dp, exp_busy}) begin
                n_fail++;
                $display("FAIL dec_1234: got an=%b seg=%b dp=%b busy=%b want seg=%b an=%b dp=%b busy=%b", an, seg, dp, busy, want, exp_an, exp_dp, exp_busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_overflow();
        value = 16'd10000; dp_in = 4'($urandom); mode = 1'b1; blank_lz = 1'b1; load = 1'b1;
        @(negedge clk); load = 1'b0;
        repeat (19) @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            n_tests++;
            if (seg !== 7'b0111111 || {seg, an, dp, busy} !== {exp_seg, exp_an, exp_dp, exp_busy}) begin
                n_fail++;
                $display("FAIL dec_ovf: got seg=%b an=%b dp=%b want seg=0111111 an=%b dp=%b", seg, an, dp, exp_an, exp_dp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_blank();
        value = 16'h0050; dp_in = 4'b0100; mode = 1'b0; blank_lz = 1'b1; load = 1'b1;
        @(negedge clk); load = 1'b0;
        repeat (3) @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            logic [6:0] ws; logic wd;
            case (an)
                4'b0111: begin ws = 7'h7F;      wd = 1'b1; end
                4'b1011: begin ws = 7'h7F;      wd = 1'b0; end
                4'b1101: begin ws = 7'b0010010; wd = 1'b1; end
                default: begin ws = 7'b1000000; wd = 1'b1; end
            endcase
            n_tests++;
            if (seg !== ws || dp !== wd || an !== exp_an) begin
                n_fail++;
                $display("FAIL blank_0050: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", an, seg, dp, exp_an, ws, wd);
            end
            @(negedge clk);
        end
        value = 16'h0000; dp_in = 4'b0000; load = 1'b1;
        @(negedge clk); load = 1'b0;
        repeat (3) @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            n_tests++;
            if (seg !== ((an == 4'b1110) ? 7'b1000000 : 7'h7F) || {seg, an, dp} !== {exp_seg, exp_an, exp_dp}) begin
                n_fail++;
                $display("FAIL blank_zero: got an=%b seg=%b dp=%b want seg=%b an=%b", an, seg, dp, exp_seg, exp_an);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        value = 16'd4321; mode = 1'b1; blank_lz = 1'b0; dp_in = 4'b0001; load = 1'b1;
        @(negedge clk); load = 1'b0;
        repeat (16) @(negedge clk);
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_done_busy: got busy=%b want 1", busy); end
        value = 16'hBEEF; mode = 1'b0; dp_in = 4'b1000; load = 1'b1;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_busy: got busy=%b want 0", busy); end
        @(negedge clk); load = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            n_tests++;
            if ({seg, an, dp, busy} !== {exp_seg, exp_an, exp_dp, exp_busy}) begin
                n_fail++;
                $display("FAIL b2b_model: got seg=%b an=%b dp=%b busy=%b want %b/%b/%b/%b", seg, an, dp, busy, exp_seg, exp_an, exp_dp, exp_busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        value = 16'd9876; mode = 1'b1; blank_lz = 1'b0; dp_in = 4'b0000; load = 1'b1;
        @(negedge clk); load = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || seg !== 7'h7F || an !== 4'hF) begin
            n_fail++;
            $display("FAIL rstmid_abort: got busy=%b seg=%b an=%b want 0/1111111/1111", busy, seg, an);
        end
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (an !== 4'b1110 || seg !== 7'b1000000) begin
            n_fail++;
            $display("FAIL rstmid_clear: got an=%b seg=%b want 1110/1000000", an, seg);
        end
        value = 16'h0001; mode = 1'b0; load = 1'b1;
        @(negedge clk); load = 1'b0;
        repeat (3) @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            n_tests++;
            if (seg !== ((an == 4'b1110) ? 7'b1111001 : 7'b1000000) || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_hex1: got an=%b seg=%b busy=%b", an, seg, busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            n_tests++;
            if ({seg, an, dp, busy} !== {exp_seg, exp_an, exp_dp, exp_busy}) begin
                n_fail++;
                if (n_fail < 40)
                    $display("FAIL random_c%0d: got seg=%b an=%b dp=%b busy=%b want %b/%b/%b/%b", c, seg, an, dp, busy, exp_seg, exp_an, exp_dp, exp_busy);
            end
            load     = ($urandom_range(0, 5) == 0);
            mode     = 1'($urandom);
            blank_lz = 1'($urandom);
            dp_in    = 4'($urandom);
            case ($urandom_range(0, 3))
                0:       value = 16'($urandom);
                1:       value = 16'($urandom_range(0, 99));
                2:       value = 16'($urandom_range(9000, 11000));
                default: value = 16'($urandom_range(0, 9999));
            endcase
            @(negedge clk);
        end
        load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_hex_scan();
        test_decimal();
        test_overflow();
        test_blank();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
